// File: rtl/sdram_port_arbiter_if.sv
// Handshake bundle between the SDRAM port arbiter, its two requesters and the controller.
// Ports: write requester (w_*), read requester (r_*), controller command/strobe side (c_*).
// slave = arbiter view; master = the surrounding requesters/controller view.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 9
);
  // write requester
  logic              w_req;
  logic [ADDR_W-1:0] w_addr;
  logic [LEN_W-1:0]  w_len;
  logic [DATA_W-1:0] w_data;
  logic              w_idle;
  logic              w_ack;
  logic              w_data_next;
  // read requester
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic              r_urgent;
  logic              r_ack;
  logic [DATA_W-1:0] r_data;
  logic              r_data_valid;
  // controller
  logic              c_idle;
  logic              c_ack;
  logic              c_data_next;
  logic              c_rd_valid;
  logic [DATA_W-1:0] c_rd_data;
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [LEN_W-1:0]  c_len;
  logic [DATA_W-1:0] c_wr_data;

  modport slave (
    input  w_req, w_addr, w_len, w_data,
    input  r_req, r_addr, r_len, r_urgent,
    input  c_idle, c_ack, c_data_next, c_rd_valid, c_rd_data,
    output w_idle, w_ack, w_data_next,
    output r_ack, r_data, r_data_valid,
    output c_req, c_we, c_addr, c_len, c_wr_data
  );

  modport master (
    output w_req, w_addr, w_len, w_data,
    output r_req, r_addr, r_len, r_urgent,
    output c_idle, c_ack, c_data_next, c_rd_valid, c_rd_data,
    input  w_idle, w_ack, w_data_next,
    input  r_ack, r_data, r_data_valid,
    input  c_req, c_we, c_addr, c_len, c_wr_data
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between a pixel writer and a VGA scanline reader.
// Latency: c_req rises 1 cycle after a grant decision; acks/strobes/read data pass through combinationally.
// Backpressure: bursts wait on c_idle/c_ack and controller beat strobes; requesters hold req until ack.
// Ports: mem_clk, reset (async active-low), bus (sdram_port_arbiter_if.slave: w_*, r_*, c_* groups).
module sdram_port_arbiter #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 9,
  parameter int WR_STARVE = 64
) (
  input  logic                 mem_clk,
  input  logic                 reset,
  sdram_port_arbiter_if.slave  bus
);

  localparam int SW = $clog2(WR_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(WR_STARVE);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_WR  = 3'd1,
    DATA_WR = 3'd2,
    REQ_RD  = 3'd3,
    DATA_RD = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              c_req_q, c_req_d;
  logic              c_we_q, c_we_d;
  logic [ADDR_W-1:0] c_addr_q, c_addr_d;
  logic [LEN_W-1:0]  c_len_q, c_len_d;
  logic              last_wr_q, last_wr_d;   // 1 = write was granted most recently
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic              urgent_rd;
  logic              wr_beat, rd_beat, beat, last_beat;
  logic              grant_wr, grant_rd;
  logic [LEN_W-1:0]  len_eff;
  logic [DATA_W-1:0] rd_data_gated;

  // Urgent video reads win only while the pending write has not been starved too long.
  assign urgent_rd = bus.r_req & bus.r_urgent & (starve_cnt_q < STARVE_MAX);

  // A beat landing in the same cycle as c_ack belongs to the burst being accepted.
  assign wr_beat = bus.c_data_next &
                   ((state_q == DATA_WR) | ((state_q == REQ_WR) & bus.c_ack));
  assign rd_beat = bus.c_rd_valid &
                   ((state_q == DATA_RD) | ((state_q == REQ_RD) & bus.c_ack));
  assign beat    = wr_beat | rd_beat;

  assign len_eff   = (c_len_q == '0) ? LEN_W'(1) : c_len_q;
  assign last_beat = (beat_cnt_q == len_eff - LEN_W'(1));

  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_q == IDLE && bus.c_idle) begin
      if (urgent_rd) begin
        grant_rd = 1'b1;
      end else if (bus.w_req && bus.r_req) begin
        grant_wr = ~last_wr_q;
        grant_rd = last_wr_q;
      end else if (bus.w_req) begin
        grant_wr = 1'b1;
      end else if (bus.r_req) begin
        grant_rd = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    c_req_d      = c_req_q;
    c_we_d       = c_we_q;
    c_addr_d     = c_addr_q;
    c_len_d      = c_len_q;
    last_wr_d    = last_wr_q;
    beat_cnt_d   = beat_cnt_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          c_addr_d   = bus.w_addr;
          c_len_d    = bus.w_len;
          c_we_d     = 1'b1;
          c_req_d    = 1'b1;
          last_wr_d  = 1'b1;
          beat_cnt_d = '0;
          state_d    = REQ_WR;
        end else if (grant_rd) begin
          c_addr_d   = bus.r_addr;
          c_len_d    = bus.r_len;
          c_we_d     = 1'b0;
          c_req_d    = 1'b1;
          last_wr_d  = 1'b0;
          beat_cnt_d = '0;
          state_d    = REQ_RD;
        end
      end
      REQ_WR: begin
        if (bus.c_ack) begin
          c_req_d = 1'b0;
          state_d = DATA_WR;
        end
      end
      REQ_RD: begin
        if (bus.c_ack) begin
          c_req_d = 1'b0;
          state_d = DATA_RD;
        end
      end
      default: ;
    endcase

    // Beat counting is shared by both directions; the final beat overrides the ack transition.
    if (beat) begin
      if (last_beat) begin
        state_d = IDLE;
      end else begin
        beat_cnt_d = beat_cnt_q + LEN_W'(1);
      end
    end

    if (grant_wr) begin
      starve_cnt_d = '0;
    end else if (bus.w_req && state_q != REQ_WR && state_q != DATA_WR &&
                 starve_cnt_q < STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
  end

  always_ff @(posedge mem_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      c_req_q      <= 1'b0;
      c_we_q       <= 1'b0;
      c_addr_q     <= '0;
      c_len_q      <= '0;
      last_wr_q    <= 1'b0;
      starve_cnt_q <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      c_req_q      <= c_req_d;
      c_we_q       <= c_we_d;
      c_addr_q     <= c_addr_d;
      c_len_q      <= c_len_d;
      last_wr_q    <= last_wr_d;
      starve_cnt_q <= starve_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign rd_data_gated = rd_beat ? bus.c_rd_data : '0;

  assign bus.w_idle       = (state_q == IDLE) & bus.c_idle & ~urgent_rd;
  assign bus.w_ack        = (state_q == REQ_WR) & bus.c_ack;
  assign bus.r_ack        = (state_q == REQ_RD) & bus.c_ack;
  assign bus.w_data_next  = wr_beat;
  assign bus.r_data_valid = rd_beat;
  assign bus.r_data       = rd_data_gated;
  assign bus.c_req        = c_req_q;
  assign bus.c_we         = c_we_q;
  assign bus.c_addr       = c_addr_q;
  assign bus.c_len        = c_len_q;
  assign bus.c_wr_data    = bus.w_data;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

  localparam int ADDR_W    = 25;
  localparam int DATA_W    = 32;
  localparam int LEN_W     = 9;
  localparam int WR_STARVE = 64;

  logic mem_clk = 1'b0;
  logic reset   = 1'b0;
  always #5 mem_clk = ~mem_clk;

  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus_if ();

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .WR_STARVE(WR_STARVE)
  ) dut (
    .mem_clk (mem_clk),
    .reset   (reset),
    .bus     (bus_if)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One "current burst" record plus the arbitration history.
  bit              m_busy, m_acked, m_we, m_last_w;
  int              m_left, m_starve;
  logic [ADDR_W-1:0] m_addr;
  logic [LEN_W-1:0]  m_len;

  // observation counters and grant log (1 = write)
  int n_wack, n_rack, n_wdn, n_rdv;
  bit last_wack, last_rack, prev_c_req;
  bit grant_log[$];

  // controller emulator state
  int ack_dly, p_strobe, p_idle, ctl_left, req_age;
  bit stray;

  task automatic m_reset();
    m_busy = 0; m_acked = 0; m_we = 0; m_last_w = 0;
    m_left = 0; m_starve = 0; m_addr = '0; m_len = '0;
    prev_c_req = 0; ctl_left = 0; req_age = 0;
    grant_log.delete();
  endtask

  task automatic clr_cnt();
    n_wack = 0; n_rack = 0; n_wdn = 0; n_rdv = 0;
  endtask

  // Controller behaviour: ack after ack_dly cycles of c_req, then deliver c_len beats.
  task automatic ctl_drive();
    bit s;
    bus_if.c_idle = ($urandom_range(99) < p_idle);
    if (bus_if.c_req) req_age++; else req_age = 0;
    bus_if.c_ack = bus_if.c_req && (req_age > ack_dly);
    if (bus_if.c_ack) ctl_left = (bus_if.c_len == 0) ? 1 : int'(bus_if.c_len);
    s = (ctl_left > 0) && ($urandom_range(99) < p_strobe);
    if (s) ctl_left--;
    bus_if.c_data_next = s && bus_if.c_we;
    bus_if.c_rd_valid  = s && !bus_if.c_we;
    bus_if.c_rd_data   = $urandom;
    bus_if.w_data      = $urandom;
    if (stray && !s && ctl_left == 0) begin
      bus_if.c_data_next = $urandom_range(1);
      bus_if.c_rd_valid  = $urandom_range(1);
      if (!bus_if.c_req) bus_if.c_ack = $urandom_range(1);
    end
  endtask

  // One clock: compare at negedge against the model, advance the model after the edge.
  task automatic cycle();
    bit urg, strobe, fwd, gw, gr, ack;
    int nstarve;
    logic [ADDR_W-1:0] na;
    logic [LEN_W-1:0]  nl;
    @(negedge mem_clk);
    urg    = bus_if.r_req && bus_if.r_urgent && (m_starve < WR_STARVE);
    ack    = bus_if.c_ack;
    strobe = m_we ? bus_if.c_data_next : bus_if.c_rd_valid;
    fwd    = m_busy && (m_acked || ack) && strobe;
    chk("c_req",        bus_if.c_req,        m_busy && !m_acked);
    chk("c_we",         bus_if.c_we,         m_we);
    chk("c_addr",       bus_if.c_addr,       m_addr);
    chk("c_len",        bus_if.c_len,        m_len);
    chk("w_ack",        bus_if.w_ack,        m_busy && !m_acked && m_we && ack);
    chk("r_ack",        bus_if.r_ack,        m_busy && !m_acked && !m_we && ack);
    chk("w_data_next",  bus_if.w_data_next,  fwd && m_we);
    chk("r_data_valid", bus_if.r_data_valid, fwd && !m_we);
    chk("r_data",       bus_if.r_data,       (fwd && !m_we) ? bus_if.c_rd_data : '0);
    chk("w_idle",       bus_if.w_idle,       !m_busy && bus_if.c_idle && !urg);
    chk("c_wr_data",    bus_if.c_wr_data,    bus_if.w_data);
    n_wack += bus_if.w_ack; n_rack += bus_if.r_ack;
    n_wdn  += bus_if.w_data_next; n_rdv += bus_if.r_data_valid;
    last_wack = bus_if.w_ack; last_rack = bus_if.r_ack;
    if (bus_if.c_req && !prev_c_req) grant_log.push_back(bus_if.c_we);
    prev_c_req = bus_if.c_req;

    gw = 0; gr = 0;
    if (!m_busy && bus_if.c_idle) begin
      if (urg) gr = 1;
      else if (bus_if.w_req && bus_if.r_req) begin
        if (m_last_w) gr = 1; else gw = 1;
      end
      else if (bus_if.w_req) gw = 1;
      else if (bus_if.r_req) gr = 1;
    end
    nstarve = m_starve;
    if (gw) nstarve = 0;
    else if (bus_if.w_req && !(m_busy && m_we) && m_starve < WR_STARVE) nstarve = m_starve + 1;
    na = gw ? bus_if.w_addr : bus_if.r_addr;
    nl = gw ? bus_if.w_len  : bus_if.r_len;

    @(posedge mem_clk);
    #1;
    m_starve = nstarve;
    if (m_busy) begin
      if (ack) m_acked = 1;
      if (fwd) begin
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
    end else if (gw || gr) begin
      m_busy = 1; m_acked = 0; m_we = gw; m_last_w = gw;
      m_addr = na; m_len = nl;
      m_left = (nl == 0) ? 1 : int'(nl);
    end
  endtask

  task automatic step();
    ctl_drive();
    cycle();
  endtask

  task automatic idle_reqs();
    bus_if.w_req = 0; bus_if.r_req = 0; bus_if.r_urgent = 0;
    bus_if.w_addr = '0; bus_if.r_addr = '0; bus_if.w_len = '0; bus_if.r_len = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_reqs();
    bus_if.c_idle = 0; bus_if.c_ack = 0; bus_if.c_data_next = 0;
    bus_if.c_rd_valid = 0; bus_if.c_rd_data = '0; bus_if.w_data = '0;
    repeat (2) @(posedge mem_clk);
    #1;
    reset = 1'b1;
    m_reset();
  endtask

  initial begin
    bit found;
    int reads_after;
    ack_dly = 3; p_strobe = 100; p_idle = 100; stray = 0;
    clr_cnt();
    do_reset();

    // reset state
    chk("rst_c_req",  bus_if.c_req, 0);
    chk("rst_c_addr", bus_if.c_addr, 0);
    chk("rst_c_len",  bus_if.c_len, 0);
    chk("rst_c_we",   bus_if.c_we, 0);

    // single write, ack 3 cycles after c_req, beat with the ack
    bus_if.w_req = 1; bus_if.w_addr = 25'h0000100; bus_if.w_len = 1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (last_wack) bus_if.w_req = 0;
    end
    chk("wr1_acks",  n_wack, 1);
    chk("wr1_beats", n_wdn, 1);
    chk("wr1_we",    bus_if.c_we, 1);
    chk("wr1_addr",  bus_if.c_addr, 25'h100);
    chk("wr1_done",  bus_if.c_req, 0);

    // 8-beat read burst with gaps between beats
    clr_cnt(); ack_dly = 1; p_strobe = 60;
    bus_if.r_req = 1; bus_if.r_addr = 25'h1000; bus_if.r_len = 8;
    for (int i = 0; i < 50; i++) begin
      step();
      if (last_rack) bus_if.r_req = 0;
    end
    chk("rd8_acks",  n_rack, 1);
    chk("rd8_beats", n_rdv, 8);
    chk("rd8_addr",  bus_if.c_addr, 25'h1000);

    // len=0 behaves as one beat
    clr_cnt(); p_strobe = 100; ack_dly = 0;
    bus_if.w_req = 1; bus_if.w_addr = 25'h1ABCDE; bus_if.w_len = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_wack) bus_if.w_req = 0;
    end
    chk("len0_beats", n_wdn, 1);

    // stray strobes with nothing granted are not forwarded
    clr_cnt(); p_idle = 0; stray = 1;
    for (int i = 0; i < 12; i++) step();
    chk("stray_wdn", n_wdn, 0);
    chk("stray_rdv", n_rdv, 0);
    stray = 0; p_idle = 100;

    // round robin from reset: W, R, W, R
    do_reset(); clr_cnt(); ack_dly = 1; p_strobe = 100;
    bus_if.w_req = 1; bus_if.w_len = 1; bus_if.w_addr = 25'h22;
    bus_if.r_req = 1; bus_if.r_len = 1; bus_if.r_addr = 25'h33;
    for (int i = 0; i < 80 && grant_log.size() < 4; i++) step();
    chk("rr_count", grant_log.size() >= 4, 1);
    if (grant_log.size() >= 4) begin
      chk("rr_g0", grant_log[0], 1);
      chk("rr_g1", grant_log[1], 0);
      chk("rr_g2", grant_log[2], 1);
      chk("rr_g3", grant_log[3], 0);
    end

    // urgent reads starve the writer until the guard forces it through
    do_reset(); clr_cnt(); ack_dly = 0;
    bus_if.w_req = 1; bus_if.w_len = 1; bus_if.r_req = 1; bus_if.r_len = 1; bus_if.r_urgent = 1;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      foreach (grant_log[k]) if (grant_log[k]) found = 1;
    end
    chk("starve_wr_grant", found, 1);
    chk("starve_first_rd", grant_log.size() > 1 && grant_log[0] == 0, 1);
    reads_after = grant_log.size();
    for (int i = 0; i < 20; i++) step();
    chk("starve_rd_resume", grant_log.size() > reads_after && grant_log[reads_after] == 0, 1);

    // randomized traffic
    do_reset(); idle_reqs(); clr_cnt(); p_idle = 80; p_strobe = 70;
    for (int i = 0; i < 2500; i++) begin
      stray = ($urandom_range(99) < 10);
      if (req_age == 0) ack_dly = $urandom_range(3);
      if (last_wack || (bus_if.w_req && $urandom_range(99) < 3)) bus_if.w_req = 0;
      else if (!bus_if.w_req && $urandom_range(99) < 25) begin
        bus_if.w_req = 1; bus_if.w_addr = ADDR_W'($urandom); bus_if.w_len = LEN_W'($urandom_range(5));
      end
      if (last_rack || (bus_if.r_req && $urandom_range(99) < 3)) bus_if.r_req = 0;
      else if (!bus_if.r_req && $urandom_range(99) < 25) begin
        bus_if.r_req = 1; bus_if.r_addr = ADDR_W'($urandom); bus_if.r_len = LEN_W'($urandom_range(5));
      end
      bus_if.r_urgent = ($urandom_range(99) < 20);
      step();
    end

    // asynchronous reset in the middle of a read burst
    stray = 0; p_idle = 100; p_strobe = 30; ack_dly = 1;
    for (int i = 0; i < 30 && m_busy; i++) step();
    idle_reqs();
    bus_if.r_req = 1; bus_if.r_addr = 25'h777; bus_if.r_len = 8;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (last_rack) bus_if.r_req = 0;
      found = m_busy && m_acked && !m_we && m_left > 1;
    end
    chk("mrst_setup", found, 1);
    bus_if.c_rd_valid = 1; bus_if.c_rd_data = 32'hDEADBEEF; bus_if.r_req = 0;
    #2 reset = 1'b0;
    #1;
    chk("mrst_c_req",  bus_if.c_req, 0);
    chk("mrst_rdv",    bus_if.r_data_valid, 0);
    chk("mrst_rdata",  bus_if.r_data, 0);
    chk("mrst_c_addr", bus_if.c_addr, 0);
    @(posedge mem_clk);
    #1;
    reset = 1'b1;
    m_reset();
    bus_if.c_rd_valid = 0;
    for (int i = 0; i < 5; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
